// File: rtl/morra_pkg.sv
// Shared codes and constants for the morra tournament scorekeeper.
package morra_pkg;
  typedef enum logic [1:0] {
    NESSUNO = 2'b00,
    G1      = 2'b01,
    G2      = 2'b10,
    PARI    = 2'b11
  } esito_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GIOCO = 2'b01,
    FINE  = 2'b10
  } stato_torneo_t;

  localparam int TARGET_MIN = 1;
endpackage

// File: rtl/morra_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module morra_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/morra_torneo.sv
// Tournament scorekeeper fed by the MorraCinese FSMD; 1-cycle registered outputs.
// Optional outcome history enabled by MORRA_STORICO_EN.
module morra_torneo
  import morra_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int MAN_W = 8
`ifdef MORRA_STORICO_EN
  , parameter int STORIA_DEPTH = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       MANCHE,
  input  logic [1:0]       PARTITA,
  input  logic             NUOVO_TORNEO,
  input  logic [2:0]       OBIETTIVO,
  output logic [CNT_W-1:0] VITTORIE_G1,
  output logic [CNT_W-1:0] VITTORIE_G2,
  output logic [CNT_W-1:0] PAREGGI,
  output logic [MAN_W-1:0] MANCHE_TOT,
  output logic [1:0]       TORNEO,
  output logic             ATTIVO
`ifdef MORRA_STORICO_EN
  , output logic [2*STORIA_DEPTH-1:0] STORICO
`endif
);
  stato_torneo_t   stato;
  logic [2:0]      target;
  logic            prev_fine;
  logic            fine, conta;
  logic            inc_g1, inc_g2, inc_pa, inc_man;
  logic            hit_g1, hit_g2;
  logic [CNT_W-1:0] g1_next, g2_next;

  // A result held for several cycles is one partita; 00 in between re-arms detection.
  assign fine    = (PARTITA != NESSUNO) && !prev_fine;
  assign conta   = (stato == GIOCO) && fine && !NUOVO_TORNEO;
  assign inc_g1  = conta && (PARTITA == G1);
  assign inc_g2  = conta && (PARTITA == G2);
  assign inc_pa  = conta && (PARTITA == PARI);
  assign inc_man = (stato == GIOCO) && !NUOVO_TORNEO && (MANCHE != NESSUNO);

  assign g1_next = (VITTORIE_G1 == '1) ? VITTORIE_G1 : VITTORIE_G1 + CNT_W'(1);
  assign g2_next = (VITTORIE_G2 == '1) ? VITTORIE_G2 : VITTORIE_G2 + CNT_W'(1);
  assign hit_g1  = inc_g1 && (32'(g1_next) >= 32'(target));
  assign hit_g2  = inc_g2 && (32'(g2_next) >= 32'(target));

  morra_sat_cnt #(.W(CNT_W)) u_cnt_g1 (.clk(clk), .rst(rst), .clr(NUOVO_TORNEO), .inc(inc_g1),  .cnt(VITTORIE_G1));
  morra_sat_cnt #(.W(CNT_W)) u_cnt_g2 (.clk(clk), .rst(rst), .clr(NUOVO_TORNEO), .inc(inc_g2),  .cnt(VITTORIE_G2));
  morra_sat_cnt #(.W(CNT_W)) u_cnt_pa (.clk(clk), .rst(rst), .clr(NUOVO_TORNEO), .inc(inc_pa),  .cnt(PAREGGI));
  morra_sat_cnt #(.W(MAN_W)) u_cnt_mt (.clk(clk), .rst(rst), .clr(NUOVO_TORNEO), .inc(inc_man), .cnt(MANCHE_TOT));

  always_ff @(posedge clk) begin
    if (rst) begin
      stato     <= IDLE;
      TORNEO    <= NESSUNO;
      ATTIVO    <= 1'b0;
      target    <= 3'(TARGET_MIN);
      prev_fine <= 1'b0;
    end else begin
      prev_fine <= (PARTITA != NESSUNO);
      if (NUOVO_TORNEO) begin
        stato  <= GIOCO;
        ATTIVO <= 1'b1;
        TORNEO <= NESSUNO;
        target <= (OBIETTIVO == 3'd0) ? 3'(TARGET_MIN) : OBIETTIVO;
      end else if (hit_g1) begin
        stato  <= FINE;
        ATTIVO <= 1'b0;
        TORNEO <= G1;
      end else if (hit_g2) begin
        stato  <= FINE;
        ATTIVO <= 1'b0;
        TORNEO <= G2;
      end
    end
  end

`ifdef MORRA_STORICO_EN
  // Newest counted partita code enters at the bottom.
  always_ff @(posedge clk) begin
    if (rst || NUOVO_TORNEO)
      STORICO <= '0;
    else if (conta)
      STORICO <= {STORICO[2*STORIA_DEPTH-3:0], PARTITA};
  end
`endif
endmodule
